// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
//
// Shared definitions for the asynchronous-input conditioning blocks.
//
// Contents:
//   SYNC_FF_MIN / SYNC_FF_MAX : legal range for the synchronizer depth
//   WIDTH_MAX                 : largest supported number of independent bits
//   FILTER_MAX                : largest supported stability filter length
//   cnt_width()               : width of a per-bit stability counter
// -----------------------------------------------------------------------------
package cdc_pkg;

    localparam int SYNC_FF_MIN = 2;
    localparam int SYNC_FF_MAX = 10;
    localparam int WIDTH_MAX   = 1024;
    localparam int FILTER_MAX  = 65535;

    // The counter holds values 0 .. filter_cycles-1. One spare code is kept
    // so the width is never zero, which also covers filter_cycles == 1.
    function automatic int cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage : cdc_pkg

// File: rtl/cdc_array_filter_if.sv
// -----------------------------------------------------------------------------
// cdc_array_filter_if
//
// Signal bundle between an asynchronous source and the conditioner.
//
// Signals:
//   async_in [WIDTH]  asynchronous inputs, no source clock
//   dest_out [WIDTH]  filtered, synchronized level
//   rise     [WIDTH]  one-cycle pulse on a 0->1 change of dest_out
//   fall     [WIDTH]  one-cycle pulse on a 1->0 change of dest_out
//   changed           OR of all rise/fall bits, registered alongside them
//
// Modports:
//   master : the side that produces async_in and consumes the results
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface cdc_array_filter_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] dest_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output async_in,
        input  dest_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  async_in,
        output dest_out,
        output rise,
        output fall,
        output changed
    );

endinterface : cdc_array_filter_if

// File: rtl/cdc_bit_filter.sv
// -----------------------------------------------------------------------------
// cdc_bit_filter
//
// Stability filter and edge detector for one already-synchronized bit.
// A difference between the synchronized input and the held output has to
// persist for FILTER_CYCLES consecutive clocks before the output follows it.
// Any return to the held level restarts the count from zero.
//
// Parameters:
//   FILTER_CYCLES : consecutive cycles a change must persist (>= 1)
//   RESET_BIT     : value loaded into dest_out on reset
//
// Ports:
//   clk      in   destination clock
//   rst      in   synchronous, active-high reset
//   s        in   synchronized input bit (last stage of the sync chain)
//   dest_out out  filtered level, registered
//   rise     out  one-cycle pulse, registered, when dest_out goes 0->1
//   fall     out  one-cycle pulse, registered, when dest_out goes 1->0
//   accept   out  combinational: dest_out takes s at the coming edge; lets
//                 the parent register an OR of all pulses on the same edge
// -----------------------------------------------------------------------------
module cdc_bit_filter
    import cdc_pkg::*;
#(
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic dest_out,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             differs;

    assign differs = (s != dest_out);

    // The counter is cleared on every acceptance and on every agreement, so
    // it can never pass CNT_LAST; equality is the whole terminal condition.
    assign accept = differs && (cnt == CNT_LAST);

    // NOTE: every register here is written with <= so all of them see the
    // pre-edge values of each other, exactly as the flops do in hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dest_out <= RESET_BIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            rise <= 1'b0;
            fall <= 1'b0;
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                // The change is accepted; s is the new level, so only one of
                // rise/fall can go high.
                dest_out <= s;
                cnt      <= '0;
                rise     <= s;
                fall     <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : cdc_bit_filter

// File: rtl/cdc_array_filter.sv
// -----------------------------------------------------------------------------
// cdc_array_filter
//
// Multi-bit conditioner for slow, independent asynchronous status/control
// bits (buttons, GPIO, link-up, external flags). Each bit is synchronized
// through a DEST_SYNC_FF-stage chain, then passed through its own stability
// filter so short pulses are rejected, then edge-detected. Bits never
// interact, so this is not suitable for coherent multi-bit buses.
//
// Parameters:
//   DEST_SYNC_FF  : synchronizer stages, 2..10
//   FILTER_CYCLES : cycles a synchronized change must persist, 1..65535
//   WIDTH         : number of independent bits, 1..1024
//   RESET_VALUE   : value loaded into the sync chain and dest_out on reset
//
// Ports:
//   clk  in    destination clock, the only clock
//   rst  in    synchronous, active-high reset
//   bus  slave async_in in, dest_out/rise/fall/changed out (all registered)
//
// Timing: a change at async_in that is stable before edge E1 reaches the last
// sync stage after E(DEST_SYNC_FF) and the outputs after
// E(DEST_SYNC_FF + FILTER_CYCLES); metastability may add one cycle.
// -----------------------------------------------------------------------------
module cdc_array_filter
    import cdc_pkg::*;
#(
    parameter int               DEST_SYNC_FF  = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter int               WIDTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input logic               clk,
    input logic               rst,
    cdc_array_filter_if.slave bus
);

    // -------------------------------------------------------------------------
    // Parameter range checks, evaluated at elaboration.
    // -------------------------------------------------------------------------
    if (DEST_SYNC_FF < SYNC_FF_MIN || DEST_SYNC_FF > SYNC_FF_MAX) begin : g_drc_sync_ff
        $error("cdc_array_filter: DEST_SYNC_FF=%0d outside %0d..%0d",
               DEST_SYNC_FF, SYNC_FF_MIN, SYNC_FF_MAX);
    end

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_MAX) begin : g_drc_filter
        $error("cdc_array_filter: FILTER_CYCLES=%0d outside 1..%0d",
               FILTER_CYCLES, FILTER_MAX);
    end

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_drc_width
        $error("cdc_array_filter: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end

    // -------------------------------------------------------------------------
    // Synchronizer chain. The attribute keeps the stages packed together and
    // out of retiming so the metastability settling time is preserved.
    // -------------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync [DEST_SYNC_FF];

    logic [WIDTH-1:0] s;

    // NOTE: sync is an array of flops, not a RAM, so resetting every entry in
    // a loop is legal and maps to plain reset logic on each stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEST_SYNC_FF; i++) begin
                sync[i] <= RESET_VALUE;
            end
        end else begin
            sync[0] <= bus.async_in;
            for (int i = 1; i < DEST_SYNC_FF; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign s = sync[DEST_SYNC_FF-1];

    // -------------------------------------------------------------------------
    // Per-bit stability filters.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] dest_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] accept;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        cdc_bit_filter #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_BIT     (RESET_VALUE[b])
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .s        (s[b]),
            .dest_out (dest_q[b]),
            .rise     (rise_q[b]),
            .fall     (fall_q[b]),
            .accept   (accept[b])
        );
    end

    // -------------------------------------------------------------------------
    // changed: registered from the acceptance terms rather than from the
    // registered pulses, so it lands on the same edge as rise/fall instead of
    // one cycle later.
    // -------------------------------------------------------------------------
    logic changed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept;
        end
    end

    assign bus.dest_out = dest_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.changed  = changed_q;

endmodule : cdc_array_filter

// File: tb/tb_cdc_array_filter.sv
// -----------------------------------------------------------------------------
// tb_cdc_array_filter
//
// Directed bench for cdc_array_filter. Three instances share clk/rst:
//   dut0 : WIDTH=4, DEST_SYNC_FF=2,  FILTER_CYCLES=4, RESET_VALUE=4'b0000
//   dut1 : WIDTH=4, DEST_SYNC_FF=10, FILTER_CYCLES=1, RESET_VALUE=4'b0000
//   dut2 : WIDTH=4, DEST_SYNC_FF=2,  FILTER_CYCLES=4, RESET_VALUE=4'b1111
// Directed steps drive inputs 1 ns after a rising edge; the next rising edge
// is called E1. A final phase toggles dut0 inputs at unaligned times and
// compares against a window-based reference model with +/-1 cycle tolerance.
// -----------------------------------------------------------------------------
module tb_cdc_array_filter;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_array_filter_if #(.WIDTH(4)) bus0 ();
    cdc_array_filter_if #(.WIDTH(4)) bus1 ();
    cdc_array_filter_if #(.WIDTH(4)) bus2 ();

    cdc_array_filter #(
        .DEST_SYNC_FF(2), .FILTER_CYCLES(4), .WIDTH(4), .RESET_VALUE(4'b0000)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    cdc_array_filter #(
        .DEST_SYNC_FF(10), .FILTER_CYCLES(1), .WIDTH(4), .RESET_VALUE(4'b0000)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    cdc_array_filter #(
        .DEST_SYNC_FF(2), .FILTER_CYCLES(4), .WIDTH(4), .RESET_VALUE(4'b1111)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // dut0 outputs against expected values at step e of a directed sequence.
    task automatic look0(input string tag, input int e, input logic [3:0] dest_e,
                         input logic [3:0] rise_e, input logic [3:0] fall_e,
                         input logic chg_e);
        check($sformatf("%s_dest_e%0d", tag, e), bus0.dest_out, dest_e);
        check($sformatf("%s_rise_e%0d", tag, e), bus0.rise, rise_e);
        check($sformatf("%s_fall_e%0d", tag, e), bus0.fall, fall_e);
        check($sformatf("%s_chg_e%0d", tag, e), bus0.changed, chg_e);
    endtask

    // -------------------------------------------------------------------------
    // Reference model for the random phase (dut0 configuration). At edge n
    // the filter consumes the input sampled at edge n-2; a change is accepted
    // when the last four consumed samples all differ from the held level.
    // -------------------------------------------------------------------------
    logic       rand_on = 1'b0;
    logic [3:0] hist [0:5];
    logic [3:0] m_dest, m_dest_prev, m_rise, m_rise_prev, m_fall, m_fall_prev;
    logic [3:0] diff_all, tol, lvl;

    always @(posedge clk) begin
        if (rand_on) begin
            for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = bus0.async_in;
            m_dest_prev = m_dest;
            m_rise_prev = m_rise;
            m_fall_prev = m_fall;
            diff_all = 4'hF;
            for (int k = 2; k <= 5; k++) diff_all = diff_all & (hist[k] ^ m_dest);
            m_rise = diff_all & hist[2];
            m_fall = diff_all & ~hist[2];
            m_dest = (m_dest & ~diff_all) | (hist[2] & diff_all);
            #1;
            // Bits in transition may legally be one cycle early or late.
            tol = m_dest ^ m_dest_prev;
            check("rnd_dest", bus0.dest_out, (m_dest & ~tol) | (bus0.dest_out & tol));
            tol = m_rise ^ m_rise_prev;
            check("rnd_rise", bus0.rise, (m_rise & ~tol) | (bus0.rise & tol));
            tol = m_fall ^ m_fall_prev;
            check("rnd_fall", bus0.fall, (m_fall & ~tol) | (bus0.fall & tol));
            check("rnd_onehot", bus0.rise & bus0.fall, 4'h0);
            check("rnd_changed", bus0.changed, |(bus0.rise | bus0.fall));
            lvl = (lvl | bus0.rise) & ~bus0.fall;
            check("rnd_history", bus0.dest_out, lvl);
        end
    end

    initial begin
        rst           = 1'b1;
        bus0.async_in = 4'b0000;
        bus1.async_in = 4'b0000;
        bus2.async_in = 4'b1111;

        // ---------------- reset state ----------------
        tick(1);
        look0("reset", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("reset_dut1_dest", bus1.dest_out, 4'b0000);
        check("reset_dut2_dest", bus2.dest_out, 4'b1111);
        check("reset_dut2_pulse", {bus2.rise, bus2.fall, 3'b000, bus2.changed}, 12'h000);
        tick(2);
        rst = 1'b0;

        // ---------------- no pulse right after reset ----------------
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            look0("post_reset", e, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            check($sformatf("post_reset_dut2_dest_e%0d", e), bus2.dest_out, 4'b1111);
            check($sformatf("post_reset_dut2_chg_e%0d", e), bus2.changed, 1'b0);
            check($sformatf("post_reset_dut1_chg_e%0d", e), bus1.changed, 1'b0);
        end

        // ---------------- dut1: DEST_SYNC_FF=10, FILTER_CYCLES=1 ----------------
        bus1.async_in = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            check($sformatf("f1_rise_e%0d", e), bus1.rise, (e == 11) ? 4'b0010 : 4'b0000);
            check($sformatf("f1_dest_e%0d", e), bus1.dest_out, (e >= 11) ? 4'b0010 : 4'b0000);
            check($sformatf("f1_chg_e%0d", e), bus1.changed, e == 11);
        end

        // ---------------- dut2: RESET_VALUE=1111, bit0 falls ----------------
        bus2.async_in = 4'b1110;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check($sformatf("rv1_fall_e%0d", e), bus2.fall, (e == 6) ? 4'b0001 : 4'b0000);
            check($sformatf("rv1_rise_e%0d", e), bus2.rise, 4'b0000);
            check($sformatf("rv1_dest_e%0d", e), bus2.dest_out, (e >= 6) ? 4'b1110 : 4'b1111);
            check($sformatf("rv1_chg_e%0d", e), bus2.changed, e == 6);
        end

        // ---------------- clean step on bit 0 ----------------
        bus0.async_in = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            look0("clean", e, (e >= 6) ? 4'b0001 : 4'b0000,
                  (e == 6) ? 4'b0001 : 4'b0000, 4'b0000, e == 6);
        end

        // ---------------- 3-cycle glitch on bit 1 is rejected ----------------
        bus0.async_in = 4'b0011;
        tick(3);
        bus0.async_in = 4'b0001;
        for (int e = 4; e <= 11; e++) begin
            tick(1);
            look0("glitch3", e, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        end

        // ---------------- 4-cycle pulse on bit 1 is accepted ----------------
        bus0.async_in = 4'b0011;
        for (int e = 1; e <= 11; e++) begin
            tick(1);
            if (e == 4) bus0.async_in = 4'b0001;
            look0("pulse4", e, (e >= 6 && e <= 9) ? 4'b0011 : 4'b0001,
                  (e == 6) ? 4'b0010 : 4'b0000, (e == 10) ? 4'b0010 : 4'b0000,
                  e == 6 || e == 10);
        end

        // ---------------- bounce on bit 2 restarts the count ----------------
        bus0.async_in = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (e == 2) bus0.async_in = 4'b0001;
            if (e == 3) bus0.async_in = 4'b0101;
            look0("bounce", e, (e >= 9) ? 4'b0101 : 4'b0001,
                  (e == 9) ? 4'b0100 : 4'b0000, 4'b0000, e == 9);
        end

        // ---------------- reset mid-count on bit 3 ----------------
        bus0.async_in = 4'b1101;
        tick(4);
        rst = 1'b1;
        tick(1);
        look0("midrst", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            look0("midrst", e, (e >= 6) ? 4'b1101 : 4'b0000,
                  (e == 6) ? 4'b1101 : 4'b0000, 4'b0000, e == 6);
        end

        // ---------------- opposite simultaneous steps on bits 0 and 3 ----------------
        bus0.async_in = 4'b1100;
        tick(8);
        check("indep_setup_dest", bus0.dest_out, 4'b1100);
        bus0.async_in = 4'b0101;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            look0("indep", e, (e >= 6) ? 4'b0101 : 4'b1100,
                  (e == 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000, e == 6);
        end

        // ---------------- random unaligned toggling on dut0 ----------------
        for (int k = 0; k <= 5; k++) hist[k] = bus0.async_in;
        m_dest = bus0.async_in;
        m_rise = 4'b0000;
        m_fall = 4'b0000;
        lvl    = bus0.async_in;
        rand_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #($urandom_range(1, 9));
            bus0.async_in = bus0.async_in ^ 4'($urandom_range(0, 15));
        end
        tick(12);
        rand_on = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cdc_array_filter
